vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_scan_gen_if.sv | 22 ++
 rtl/vga_scan_gen.sv | 94 +++++++++
 tb/tb_vga_scan_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan/timing bundle driven by vga_scan_gen
interface vga_scan_gen_if;
   logic        pixel_clk;
   logic        pix_en;
   logic        hs;
   logic        vs;
   logic        display_en;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        frame_tick;
   logic [15:0] frame_count;

   modport master (
      output pixel_clk, pix_en, hs, vs, display_en,
             DrawX, DrawY, frame_tick, frame_count
   );

   modport slave (
      input  pixel_clk, pix_en, hs, vs, display_en,
             DrawX, DrawY, frame_tick, frame_count
   );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster counter with registered syncs, display enable and frame counter
// Counters advance on every other Clk; all timing outputs are decoded from the next-state position.
module vga_scan_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic           Clk,
   input  logic           Reset,
   vga_scan_gen_if.master scan
);
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic        toggle_q;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        tick_q, tick_d;
   logic [15:0] frame_count_q, frame_count_d;

   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      tick_d        = 1'b0;
      frame_count_d = frame_count_q;
      if (toggle_q) begin
         if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
               y_d           = 10'd0;
               tick_d        = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      // Decoding the next position keeps syncs aligned with DrawX/DrawY on the same edge.
      hs_d = !((x_d >= HS_START) && (x_d < HS_END));
      vs_d = !((y_d >= VS_START) && (y_d < VS_END));
      de_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         toggle_q      <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         de_q          <= 1'b1;
         tick_q        <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         toggle_q      <= ~toggle_q;
         x_q           <= x_d;
         y_q           <= y_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
         tick_q        <= tick_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign scan.pixel_clk   = toggle_q;
   assign scan.pix_en      = toggle_q;
   assign scan.hs          = hs_q;
   assign scan.vs          = vs_q;
   assign scan.display_en  = de_q;
   assign scan.DrawX       = x_q;
   assign scan.DrawY       = y_q;
   assign scan.frame_tick  = tick_q;
   assign scan.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - bench for vga_scan_gen: default-size directed checks plus small-raster model compare
module tb_vga_scan_gen;
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   vga_scan_gen_if if_a ();
   vga_scan_gen_if if_b ();

   vga_scan_gen dut_a (.Clk(Clk), .Reset(rst_a), .scan(if_a));

   vga_scan_gen #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_b (.Clk(Clk), .Reset(rst_b), .scan(if_b));

   localparam int BH = 25;
   localparam int BV = 15;
   localparam int BF = BH * BV;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   // Model of dut_b: k = Clk edges since reset released; advances = k/2.
   int k = 0;
   logic [15:0] fc_adj = 16'd0;

   always @(posedge Clk) begin
      if (rst_b) k = 0;
      else       k = k + 1;
   end

   always @(negedge Clk) begin
      int n, x, y;
      n = k / 2;
      x = n % BH;
      y = (n / BH) % BV;
      check("b_pix_en",      int'(if_b.pix_en),      k % 2);
      check("b_pixel_clk",   int'(if_b.pixel_clk),   k % 2);
      check("b_DrawX",       int'(if_b.DrawX),       x);
      check("b_DrawY",       int'(if_b.DrawY),       y);
      check("b_hs",          int'(if_b.hs),          int'(!(x >= 18 && x < 22)));
      check("b_vs",          int'(if_b.vs),          int'(!(y >= 10 && y < 12)));
      check("b_display_en",  int'(if_b.display_en),  int'(x < 16 && y < 8));
      check("b_frame_tick",  int'(if_b.frame_tick),  int'(k > 0 && k % 2 == 0 && n % BF == 0));
      check("b_frame_count", int'(if_b.frame_count), int'(16'(fc_adj + 16'(n / BF))));
   end

   initial begin
      int exp_pe [4];
      int exp_x  [4];
      int hs_low, first_x, prev_x, vs_low, de_hi, ticks, tick_fc1, tick_fc2;
      bit seen, done;

      exp_pe = '{1, 0, 1, 0};
      exp_x  = '{0, 1, 1, 2};

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("a_rst_pix_en", int'(if_a.pix_en), 0);
      check("a_rst_DrawX",  int'(if_a.DrawX),  0);
      check("a_rst_DrawY",  int'(if_a.DrawY),  0);
      check("a_rst_hs",     int'(if_a.hs),     1);
      check("a_rst_vs",     int'(if_a.vs),     1);
      check("a_rst_de",     int'(if_a.display_en), 1);
      check("a_rst_tick",   int'(if_a.frame_tick), 0);
      check("a_rst_fc",     int'(if_a.frame_count), 0);
      #1 rst_a = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check("a_start_pix_en", int'(if_a.pix_en), exp_pe[i]);
         check("a_start_DrawX",  int'(if_a.DrawX),  exp_x[i]);
      end

      // One full line at default timing.
      hs_low = 0; first_x = -1; prev_x = int'(if_a.DrawX); seen = 0; done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge Clk);
         if (!if_a.hs) begin
            if (!seen) first_x = int'(if_a.DrawX);
            seen = 1;
            hs_low++;
         end
         if (if_a.DrawY == 10'd1) begin
            done = 1;
            check("a_line_wrap_x",    int'(if_a.DrawX), 0);
            check("a_line_prev_x",    prev_x, 799);
         end
         prev_x = int'(if_a.DrawX);
      end
      check("a_line_done",     int'(done), 1);
      check("a_hs_low_clks",   hs_low, 192);
      check("a_hs_first_x",    first_x, 656);

      // Mid-line reset while hs is low.
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge Clk);
         if (if_a.DrawX == 10'd700) done = 1;
      end
      check("a_reach_700", int'(done), 1);
      check("a_hs_at_700", int'(if_a.hs), 0);
      #1 rst_a = 1'b1;
      @(negedge Clk);
      check("a_mrst_DrawX", int'(if_a.DrawX), 0);
      check("a_mrst_DrawY", int'(if_a.DrawY), 0);
      check("a_mrst_hs",    int'(if_a.hs), 1);
      check("a_mrst_vs",    int'(if_a.vs), 1);
      check("a_mrst_de",    int'(if_a.display_en), 1);
      check("a_mrst_fc",    int'(if_a.frame_count), 0);
      check("a_mrst_pix",   int'(if_a.pix_en), 0);
      #1 rst_a = 1'b0;

      // Small raster: two full frames with literal totals.
      @(negedge Clk);
      #1 rst_b = 1'b0;
      vs_low = 0; de_hi = 0; ticks = 0;
      for (int i = 0; i < 2 * BF; i++) begin
         @(negedge Clk);
         if (!if_b.vs) vs_low++;
         if (if_b.display_en) de_hi++;
         if (if_b.frame_tick) ticks++;
      end
      check("b_vs_low_clks", vs_low, 100);
      check("b_de_hi_clks",  de_hi, 256);
      check("b_frame_ticks", ticks, 1);
      check("b_fc_one",      int'(if_b.frame_count), 1);

      // Preload the frame counter near rollover.
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge Clk);
         if ((k / 2) % BF == 100) done = 1;
      end
      check("b_reach_preload", int'(done), 1);
      #1;
      force dut_b.frame_count_q = 16'hFFFE;
      fc_adj = 16'(16'hFFFE - 16'((k / 2) / BF));
      @(posedge Clk);
      @(negedge Clk);
      #1 release dut_b.frame_count_q;

      ticks = 0; tick_fc1 = -1; tick_fc2 = -1;
      for (int i = 0; i < 2000 && ticks < 2; i++) begin
         @(negedge Clk);
         if (if_b.frame_tick) begin
            ticks++;
            if (ticks == 1) tick_fc1 = int'(if_b.frame_count);
            else            tick_fc2 = int'(if_b.frame_count);
         end
      end
      check("b_roll_ticks", ticks, 2);
      check("b_roll_fc1",   tick_fc1, 65535);
      check("b_roll_fc2",   tick_fc2, 0);

      // Reset landing on the exact frame-wrap advance.
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge Clk);
         if (k % 2 == 1 && if_b.DrawX == 10'd24 && if_b.DrawY == 10'd14) done = 1;
      end
      check("b_reach_wrap", int'(done), 1);
      #1;
      rst_b  = 1'b1;
      fc_adj = 16'd0;
      @(negedge Clk);
      check("b_wrst_tick",  int'(if_b.frame_tick), 0);
      check("b_wrst_fc",    int'(if_b.frame_count), 0);
      check("b_wrst_DrawX", int'(if_b.DrawX), 0);
      check("b_wrst_DrawY", int'(if_b.DrawY), 0);
      repeat (2) @(negedge Clk);
      #1 rst_b = 1'b0;
      repeat (20) @(negedge Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
